// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
// supported opcodes, datapath mux select codes and the control word that the
// combinational decoder hands to the top level.
// -----------------------------------------------------------------------------
package processor_pkg;

  typedef enum logic [3:0] {
    RESET,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC,
    ALU_WB,
    ADDI_EXEC,
    ADDI_WB,
    BRANCH,
    JUMP
  } state_t;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath select and enable driven in one cycle
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctl_word_t;

  // True for the opcodes this controller knows how to sequence
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/processor_ctl_decode.sv
// -----------------------------------------------------------------------------
// processor_ctl_decode
// Purely combinational Moore decoder: maps the current controller state to the
// datapath control word. The only input dependencies are mem_ready (FETCH,
// MEM_WR) and zero (BRANCH).
//   state      in   current FSM state
//   mem_ready  in   unified memory completed its read/write
//   zero       in   ALU zero flag
//   ctl        out  control word for this cycle
// -----------------------------------------------------------------------------
module processor_ctl_decode
  import processor_pkg::*;
(
  input  state_t    state,
  input  logic      mem_ready,
  input  logic      zero,
  output ctl_word_t ctl
);

  always_comb begin
    // NOTE: the all-zero default covers every field in every state, so no
    // branch below can leave a field unassigned and infer a latch.
    ctl = '0;
    unique case (state)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.alu_op    = ALU_OP_ADD;
        ctl.pc_src    = PCSRC_ALU;
        // IR and PC only load on the edge that completes the fetch
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded
        ctl.alu_src_b = ALUB_IMM_SL2;
        ctl.alu_op    = ALU_OP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.alu_op    = ALU_OP_ADD;
      end
      MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = mem_ready;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_REG;
        ctl.alu_op    = ALU_OP_FUNCT;
      end
      ALU_WB: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = ALUB_REG;
        ctl.alu_op     = ALU_OP_SUB;
        ctl.pc_src     = PCSRC_ALUOUT;
        ctl.pc_write   = zero;
        ctl.instr_done = 1'b1;
      end
      JUMP: begin
        ctl.pc_src     = PCSRC_JUMP;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;  // RESET and any unused encoding drive nothing
    endcase
  end

endmodule

// File: rtl/processor_multicycle_controller.sv
// -----------------------------------------------------------------------------
// processor_multicycle_controller
// Moore FSM sequencing a shared-memory multi-cycle MIPS datapath through
// fetch / decode / execute / memory / write-back for R-type, LW, SW, BEQ,
// ADDI and J. Holds the state register, next-state logic and the sticky
// illegal_op flag; control outputs come from processor_ctl_decode.
//   clk, rst           clock; asynchronous active-high reset
//   opcode             instr[31:26] from the instruction register
//   zero               ALU zero flag
//   mem_ready          unified memory completed current access
//   pc_write .. pc_src datapath enables and mux selects
//   instr_done         pulse in the final cycle of each instruction
//   illegal_op         sticky, set leaving DECODE on an unsupported opcode
// -----------------------------------------------------------------------------
module processor_multicycle_controller
  import processor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t    state;
  ctl_word_t ctl;

  // Reset drives state to RESET asynchronously, and RESET decodes to an
  // all-zero word, so every output drops the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET;
      illegal_op <= 1'b0;
    end else begin
      // NOTE: state and flag are flops; non-blocking assignments keep every
      // reader in this edge seeing the pre-edge values.
      unique case (state)
        RESET:  state <= FETCH;
        FETCH:  state <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          unique case (opcode)
            OP_RTYPE:     state <= EXEC;
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDI_EXEC;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
          if (!is_supported(opcode)) illegal_op <= 1'b1;
        end
        MEM_ADDR:  state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:    state <= mem_ready ? MEM_WB : MEM_RD;
        MEM_WR:    state <= mem_ready ? FETCH : MEM_WR;
        EXEC:      state <= ALU_WB;
        ADDI_EXEC: state <= ADDI_WB;
        MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP: state <= FETCH;
        default:   state <= RESET;
      endcase
    end
  end

  processor_ctl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctl       (ctl)
  );

  assign pc_write   = ctl.pc_write;
  assign i_or_d     = ctl.i_or_d;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_src     = ctl.pc_src;
  assign instr_done = ctl.instr_done;

endmodule

// File: tb/tb_processor_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_processor_multicycle_controller
// Self-checking bench. For each instruction the reference model expands the
// opcode, memory wait counts and zero flag into the expected per-cycle control
// words listed for that instruction class, then replays it against the DUT.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_processor_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } exp_t;

  typedef struct {
    logic ready;
    logic zero;
    exp_t exp;
    bit   sets_illegal;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;

  int   errors = 0;
  int   checks = 0;
  bit   ill_model = 1'b0;
  step_t plan[$];

  always #5 clk = ~clk;

  processor_multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  function automatic exp_t actual();
    exp_t a;
    a = '{pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
          reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};
    return a;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b000010};
  endfunction

  // Expand one instruction into its expected cycle sequence.
  // zsel < 0 means a random zero flag in the branch cycle.
  function automatic void plan_instr(input logic [5:0] op, input int fw,
                                     input int mw, input int zsel);
    exp_t c;
    logic z;
    plan.delete();
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
      plan.push_back('{1'b0, rbit(), c, 1'b0});
    end
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1;
    plan.push_back('{1'b1, rbit(), c, 1'b0});
    c = '0; c.alu_src_b = 2'b11;
    plan.push_back('{rbit(), rbit(), c, !legal(op)});
    case (op)
      6'b000000: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 2'b10;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
        c = '0; c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
      end
      6'b100011, 6'b101011: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
        c = '0; c.i_or_d = 1;
        if (op == 6'b100011) c.mem_read = 1; else c.mem_write = 1;
        for (int i = 0; i < mw; i++) plan.push_back('{1'b0, rbit(), c, 1'b0});
        if (op == 6'b101011) c.instr_done = 1;
        plan.push_back('{1'b1, rbit(), c, 1'b0});
        if (op == 6'b100011) begin
          c = '0; c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1;
          plan.push_back('{rbit(), rbit(), c, 1'b0});
        end
      end
      6'b000100: begin
        z = (zsel < 0) ? rbit() : logic'(zsel);
        c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
        c.pc_write = z; c.instr_done = 1;
        plan.push_back('{rbit(), z, c, 1'b0});
      end
      6'b001000: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
        c = '0; c.reg_write = 1; c.instr_done = 1;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
      end
      6'b000010: begin
        c = '0; c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1;
        plan.push_back('{rbit(), rbit(), c, 1'b0});
      end
      default: ;
    endcase
  endfunction

  // Replay the first n steps of the plan (n < 0: all). Entered on a falling
  // edge, returns on a falling edge.
  task automatic run_plan(input string name, input int n);
    int lim;
    exp_t a;
    lim = (n < 0) ? plan.size() : n;
    for (int i = 0; i < lim; i++) begin
      mem_ready = plan[i].ready;
      zero      = plan[i].zero;
      #1;
      a = actual();
      checks++;
      if (a !== plan[i].exp) begin
        errors++;
        $display("FAIL %s op=%b cycle=%0d ctl got=%h exp=%h", name, opcode, i,
                 a, plan[i].exp);
      end
      checks++;
      if (illegal_op !== ill_model) begin
        errors++;
        $display("FAIL %s op=%b cycle=%0d illegal_op got=%b exp=%b", name,
                 opcode, i, illegal_op, ill_model);
      end
      @(posedge clk);
      @(negedge clk);
      if (plan[i].sets_illegal) ill_model = 1'b1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op,
                           input int fw, input int mw, input int zsel);
    opcode = op;
    plan_instr(op, fw, mw, zsel);
    run_plan(name, -1);
  endtask

  // Assert rst on a falling edge, check outputs drop at once, release one
  // cycle later and check the RESET cycle. Leaves the DUT in FETCH.
  task automatic apply_reset(input string name);
    rst = 1'b1;
    #1;
    ill_model = 1'b0;
    checks++;
    if (actual() !== exp_t'('0) || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL %s async reset outputs got=%h ill=%b exp=0", name,
               actual(), illegal_op);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    #1;
    checks++;
    if (actual() !== exp_t'('0) || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL %s reset-state outputs got=%h ill=%b exp=0", name,
               actual(), illegal_op);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    // Reach MEM_RD of a load and stall there
    opcode = 6'b100011;
    plan_instr(6'b100011, 0, 3, -1);
    run_plan("reset_setup", 4);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (!(mem_read === 1'b1 && i_or_d === 1'b1)) begin
      errors++;
      $display("FAIL reset_setup mem_rd got rd=%b iod=%b exp=1/1", mem_read,
               i_or_d);
    end
    #1;
    apply_reset("reset_mid_memrd");
    mem_ready = 1'b0;
    #1;
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
    checks++;
    if (actual() !== e) begin
      errors++;
      $display("FAIL reset_first_fetch got=%h exp=%h", actual(), e);
    end
    #1;
    run_instr("reset_then_rtype", 6'b000000, 0, 0, -1);
  endtask

  task automatic test_rtype();
    run_instr("rtype", 6'b000000, 0, 0, -1);
    run_instr("rtype_fetchwait", 6'b000000, 2, 0, -1);
  endtask

  task automatic test_lw_waits();
    run_instr("lw_wait2", 6'b100011, 0, 2, -1);
    run_instr("lw_nowait", 6'b100011, 0, 0, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 0, 0, 1);
    run_instr("beq_not_taken", 6'b000100, 0, 0, 0);
  endtask

  task automatic test_sw_j();
    run_instr("sw", 6'b101011, 0, 0, -1);
    run_instr("sw_wait", 6'b101011, 1, 3, -1);
    run_instr("jump", 6'b000010, 0, 0, -1);
    run_instr("addi", 6'b001000, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'b111111, 0, 0, -1);
    run_instr("after_illegal_j", 6'b000010, 0, 0, -1);
    run_instr("after_illegal_lw", 6'b100011, 1, 1, -1);
    apply_reset("illegal_clear");
    mem_ready = 1'b0;
    #1;
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got=%b exp=0", illegal_op);
    end
    #1;
    run_instr("post_clear_rtype", 6'b000000, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b001000, 6'b000010, 6'b000000};
    logic [5:0] op;
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    apply_reset("power_on");
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_sw_j();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/processor_multicycle_controller.md
# processor_multicycle_controller

Moore-style finite state machine that sequences a shared-memory, multi-cycle MIPS datapath through fetch, decode, execute, memory and write-back phases. It replaces one-shot opcode decoding with per-state control words and supports R-type, LW, SW, BEQ, ADDI and J. It sits between the instruction register's opcode field, the ALU zero flag and the unified memory's ready signal on the input side, and every datapath mux select and enable on the output side.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction bits [31:26] from the instruction register
- zero  in  1  ALU zero flag, valid combinationally in the same cycle
- mem_ready  in  1  unified memory has completed the current read or write
- pc_write  out  1  PC load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU output register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load enable
- mem_to_reg  out  1  register write data: 0 = ALU output, 1 = memory data register
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode from funct field
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALU output register, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  sticky flag, registered, set by an unsupported opcode

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP.
- Outputs not listed for a state are 0.
- RESET:
  - All outputs 0.
  - Next state FETCH unconditionally.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 001000 → ADDI_EXEC
    - 000010 → JUMP
    - any other opcode → FETCH, set illegal_op
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state MEM_RD if opcode=100011, otherwise MEM_WR.
- MEM_RD:
  - mem_read=1, i_or_d=1.
  - Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB:
  - reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1.
  - Next state FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1.
  - Hold until mem_ready=1; instr_done=mem_ready.
  - Next state FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state ALU_WB.
- ALU_WB:
  - reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1.
  - Next state FETCH.
- ADDI_EXEC:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state ADDI_WB.
- ADDI_WB:
  - reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
  - Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write=zero, instr_done=1.
  - Next state FETCH.
- JUMP:
  - pc_src=10, pc_write=1, instr_done=1.
  - Next state FETCH.
- illegal_op: set on the clock edge leaving DECODE with an unsupported opcode; cleared only by rst.

## Timing
- Reset:
  - rst asserted at any time forces state RESET and illegal_op=0 immediately, with no clock edge needed.
  - All outputs read 0 while rst is high.
  - An in-flight memory request is abandoned; its mem_read/mem_write drop asynchronously.
- Output decode:
  - All outputs except illegal_op are combinational from state.
  - The only input dependencies are mem_ready (FETCH, MEM_WR) and zero (BRANCH).
- Latency with mem_ready held high; each memory wait cycle adds 1 cycle:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - ADDI: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
  - illegal opcode: 2 cycles
- Memory handshake:
  - mem_read/mem_write and i_or_d stay stable for the whole wait.
  - The request completes on the rising edge where mem_ready=1.
  - mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- First fetch begins in the first cycle after rst deasserts plus one (RESET occupies one cycle).

## Structure
- Shared package processor_pkg contains:
  - state_t enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALU_OP_ADD/SUB/FUNCT
  - ALUB_REG/FOUR/IMM/IMM_SL2
  - PCSRC_ALU/ALUOUT/JUMP
- Sub-module processor_ctl_decode:
  - Purely combinational: state, mem_ready and zero → control word.
  - The top holds the state register, next-state logic and the illegal_op flop.

## Test plan
- **Reset:** assert rst mid-MEM_RD → all outputs 0 in the same cycle. Release rst → RESET for 1 cycle, then FETCH with mem_read=1, alu_src_b=01.
- **R-type:** opcode=000000, mem_ready=1 → FETCH, DECODE, EXEC (alu_op=10), ALU_WB (reg_dst=1, reg_write=1, instr_done=1); back in FETCH on cycle 5.
- **LW with waits:** opcode=100011, mem_ready low for 2 cycles in MEM_RD → mem_read=1, i_or_d=1 held for 3 cycles; MEM_WB with mem_to_reg=1; 7 cycles total.
- **BEQ:** opcode=000100 with zero=1 → pc_write=1, pc_src=01 in BRANCH. Repeat with zero=0 → pc_write=0. Both take 3 cycles.
- **SW and J:** opcode=101011 → mem_write=1 in exactly one cycle with mem_ready=1. opcode=000010 → JUMP with pc_src=10, pc_write=1.
- **Illegal opcode:** opcode=111111 → DECODE→FETCH, illegal_op=1 from the next cycle and sticky across further instructions, cleared by rst.
